// File: rtl/dm_access_unit.sv
// M/W memory-access stage: holds one request in M, drives the data-memory port,
// and registers aligned/extended load data or a fault into W for writeback.
module dm_access_unit #(
    parameter int DM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    input  logic [4:0]  req_rd,
    input  logic        stall,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    output logic [31:0] m_inst_addr,
    input  logic [31:0] m_data_rdata,
    output logic        w_grf_we,
    output logic [4:0]  w_grf_addr,
    output logic [31:0] w_grf_wdata,
    output logic [31:0] w_inst_addr,
    output logic        exc_valid,
    output logic [31:0] exc_pc
);
    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } mem_op_e;

    localparam logic [32:0] DM_BYTES = 33'(DM_WORDS) * 33'd4;

    logic        m_valid_reg, m_valid_next;
    mem_op_e     m_op_reg, m_op_next;
    logic [31:0] m_addr_reg, m_addr_next;
    logic [31:0] m_wdata_reg, m_wdata_next;
    logic [31:0] m_pc_reg, m_pc_next;
    logic [4:0]  m_rd_reg, m_rd_next;

    logic        w_valid_reg, w_valid_next;
    logic        w_load_reg, w_load_next;
    logic        w_exc_reg, w_exc_next;
    logic [4:0]  w_rd_reg, w_rd_next;
    logic [31:0] w_data_reg, w_data_next;
    logic [31:0] w_pc_reg, w_pc_next;

    logic        m_is_store, m_is_load, m_misaligned, m_fault;
    logic        m_moves, m_write;
    logic [3:0]  lane_mask;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    assign req_ready  = !stall || !m_valid_reg;
    assign m_moves    = m_valid_reg && !stall;
    assign m_is_store = (m_op_reg == OP_SW) || (m_op_reg == OP_SH) || (m_op_reg == OP_SB);
    assign m_is_load  = !m_is_store;

    always_comb begin
        m_misaligned = 1'b0;
        unique case (m_op_reg)
            OP_LW, OP_SW:         m_misaligned = (m_addr_reg[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: m_misaligned = m_addr_reg[0];
            default:              m_misaligned = 1'b0;
        endcase
    end

    assign m_fault = m_misaligned || ({1'b0, m_addr_reg} >= DM_BYTES);
    // Writes are suppressed while reset is low so an in-flight store never lands.
    assign m_write = m_moves && reset && m_is_store && !m_fault;

    always_comb begin
        lane_mask = 4'b0000;
        unique case (m_op_reg)
            OP_SW:   lane_mask = 4'b1111;
            OP_SH:   lane_mask = m_addr_reg[1] ? 4'b1100 : 4'b0011;
            OP_SB:   lane_mask = 4'b0001 << m_addr_reg[1:0];
            default: lane_mask = 4'b0000;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign m_data_byteen[gi] = m_write && lane_mask[gi];
        assign m_data_wdata[8*gi +: 8] =
            !m_valid_reg         ? 8'h00 :
            (m_op_reg == OP_SW)  ? m_wdata_reg[8*gi +: 8] :
            (m_op_reg == OP_SH)  ? m_wdata_reg[8*(gi%2) +: 8] :
            (m_op_reg == OP_SB)  ? m_wdata_reg[7:0] : 8'h00;
    end

    assign m_data_addr = m_valid_reg ? {m_addr_reg[31:2], 2'b00} : 32'h0;
    assign m_inst_addr = m_valid_reg ? m_pc_reg : 32'h0;

    assign load_byte = m_data_rdata[{m_addr_reg[1:0], 3'b000} +: 8];
    assign load_half = m_addr_reg[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];

    always_comb begin
        load_data = m_data_rdata;
        unique case (m_op_reg)
            OP_LH:   load_data = {{16{load_half[15]}}, load_half};
            OP_LHU:  load_data = {16'h0000, load_half};
            OP_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            OP_LBU:  load_data = {24'h000000, load_byte};
            default: load_data = m_data_rdata;
        endcase
    end

    always_comb begin
        m_valid_next = 1'b0;
        m_op_next    = m_op_reg;
        m_addr_next  = m_addr_reg;
        m_wdata_next = m_wdata_reg;
        m_pc_next    = m_pc_reg;
        m_rd_next    = m_rd_reg;
        if (req_valid && req_ready) begin
            m_valid_next = 1'b1;
            m_op_next    = mem_op_e'(req_op);
            m_addr_next  = req_addr;
            m_wdata_next = req_wdata;
            m_pc_next    = req_pc;
            m_rd_next    = req_rd;
        end else if (stall && m_valid_reg) begin
            m_valid_next = 1'b1;
        end

        // W takes a bubble whenever M does not advance, so results never repeat.
        w_valid_next = m_moves;
        w_load_next  = m_is_load;
        w_exc_next   = m_fault;
        w_rd_next    = m_rd_reg;
        w_pc_next    = m_pc_reg;
        w_data_next  = (m_is_load && !m_fault) ? load_data : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            m_valid_reg <= 1'b0;
            w_valid_reg <= 1'b0;
        end else begin
            m_valid_reg <= m_valid_next;
            w_valid_reg <= w_valid_next;
        end
        m_op_reg    <= m_op_next;
        m_addr_reg  <= m_addr_next;
        m_wdata_reg <= m_wdata_next;
        m_pc_reg    <= m_pc_next;
        m_rd_reg    <= m_rd_next;
        w_load_reg  <= w_load_next;
        w_exc_reg   <= w_exc_next;
        w_rd_reg    <= w_rd_next;
        w_data_reg  <= w_data_next;
        w_pc_reg    <= w_pc_next;
    end

    assign w_grf_we    = w_valid_reg && w_load_reg && !w_exc_reg && (w_rd_reg != 5'd0) && reset;
    assign w_grf_addr  = w_valid_reg ? w_rd_reg : 5'd0;
    assign w_grf_wdata = w_valid_reg ? w_data_reg : 32'h0;
    assign w_inst_addr = w_valid_reg ? w_pc_reg : 32'h0;
    assign exc_valid   = w_valid_reg && w_exc_reg;
    assign exc_pc      = (w_valid_reg && w_exc_reg) ? w_pc_reg : 32'h0;

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: directed vector table, stall/reset sequences, and
// random traffic checked against a transaction-level model with its own memory image.
module tb_dm_access_unit;
    localparam int DM_WORDS = 4096;
    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                           LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] req_pc = 32'h0;
    logic [4:0]  req_rd = 5'd0;
    logic        stall = 1'b0;
    logic [31:0] m_data_addr, m_data_wdata, m_inst_addr, m_data_rdata;
    logic [3:0]  m_data_byteen;
    logic        w_grf_we, exc_valid;
    logic [4:0]  w_grf_addr;
    logic [31:0] w_grf_wdata, w_inst_addr, exc_pc;

    dm_access_unit #(.DM_WORDS(DM_WORDS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc), .req_rd(req_rd),
        .stall(stall),
        .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
        .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr),
        .m_data_rdata(m_data_rdata),
        .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr), .w_grf_wdata(w_grf_wdata),
        .w_inst_addr(w_inst_addr), .exc_valid(exc_valid), .exc_pc(exc_pc)
    );

    always #5 clk = ~clk;

    // Bench-side data memory, written only by what the DUT drives on the port.
    logic [31:0] mem     [0:DM_WORDS-1];
    logic [31:0] ref_mem [0:DM_WORDS-1];
    assign m_data_rdata = (m_data_addr < 32'(4*DM_WORDS)) ? mem[m_data_addr[13:2]] : 32'h0;

    typedef struct {
        logic        valid;
        logic [2:0]  op;
        logic [31:0] addr, wdata, pc;
        logic [4:0]  rd;
    } mreq_t;

    typedef struct {
        logic        valid, load, fault;
        logic [4:0]  rd;
        logic [31:0] data, pc;
    } wres_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr, wdata, pc;
        logic [4:0]  rd;
        logic [3:0]  e_be;
        logic [31:0] e_maddr, e_mwdata;
        logic        e_we;
        logic [31:0] e_wdata;
        logic        e_exc;
    } vec_t;

    mreq_t mdl_m;
    wres_t mdl_w;
    bit    mdl_known = 1'b0;
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    function automatic bit ref_fault(input logic [2:0] op, input logic [31:0] addr);
        if (addr >= 32'(4*DM_WORDS)) return 1'b1;
        if ((op == LW || op == SW) && (addr % 4) != 0) return 1'b1;
        if ((op == LH || op == LHU || op == SH) && (addr % 2) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr);
        logic [31:0] word, b, h;
        word = ref_mem[addr[13:2]];
        b = (word >> (8 * (addr % 4))) & 32'hFF;
        h = (word >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        case (op)
            LB:      return (b >= 128) ? b + 32'hFFFFFF00 : b;
            LBU:     return b;
            LH:      return (h >= 32768) ? h + 32'hFFFF0000 : h;
            LHU:     return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] ref_mask(input logic [2:0] op, input logic [31:0] addr);
        case (op)
            SW:      return 4'd15;
            SH:      return ((addr % 4) >= 2) ? 4'd12 : 4'd3;
            SB:      return 4'(1 << (addr % 4));
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_lanes(input logic [2:0] op, input logic [31:0] wdata);
        case (op)
            SW:      return wdata;
            SH:      return (wdata & 32'hFFFF) * 32'h00010001;
            SB:      return (wdata & 32'hFF) * 32'h01010101;
            default: return 32'h0;
        endcase
    endfunction

    // One clock: drive at negedge, check against the model 1 ns later, then advance the model.
    task automatic do_cycle(input logic v, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] pc, input logic [4:0] rd,
                            input logic st, input logic rst_n);
        logic       exp_ready, exp_we, exp_exc;
        logic [3:0] exp_be;
        logic [3:0] mask;
        logic [31:0] lanes;
        mreq_t nm;
        wres_t nw;
        @(negedge clk);
        req_valid = v; req_op = op; req_addr = addr; req_wdata = wdata;
        req_pc = pc; req_rd = rd; stall = st; reset = rst_n;
        #1;
        cyc++;
        exp_ready = !st || !mdl_m.valid;
        if (mdl_known) begin
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            exp_be = 4'd0;
            if (mdl_m.valid && !st && rst_n && !ref_fault(mdl_m.op, mdl_m.addr))
                exp_be = ref_mask(mdl_m.op, mdl_m.addr);
            check("byteen", 32'(m_data_byteen), 32'(exp_be));
            check("m_inst_addr", m_inst_addr, mdl_m.valid ? mdl_m.pc : 32'h0);
            if (mdl_m.valid) begin
                check("m_data_addr", m_data_addr, mdl_m.addr & ~32'h3);
                check("m_data_wdata", m_data_wdata, ref_lanes(mdl_m.op, mdl_m.wdata));
            end
            exp_we  = mdl_w.valid && mdl_w.load && !mdl_w.fault && (mdl_w.rd != 0) && rst_n;
            exp_exc = mdl_w.valid && mdl_w.fault;
            check("w_grf_we", 32'(w_grf_we), 32'(exp_we));
            check("w_grf_addr", 32'(w_grf_addr), mdl_w.valid ? 32'(mdl_w.rd) : 32'h0);
            check("w_inst_addr", w_inst_addr, mdl_w.valid ? mdl_w.pc : 32'h0);
            if (exp_we) check("w_grf_wdata", w_grf_wdata, mdl_w.data);
            else if (!mdl_w.valid) check("w_grf_wdata_idle", w_grf_wdata, 32'h0);
            check("exc_valid", 32'(exc_valid), 32'(exp_exc));
            check("exc_pc", exc_pc, exp_exc ? mdl_w.pc : 32'h0);
        end
        if (v && rst_n && req_ready)
            $display("txn cyc=%0d op=%0d addr=0x%08h wdata=0x%08h pc=0x%08h rd=%0d",
                     cyc, op, addr, wdata, pc, rd);
        for (int i = 0; i < 4; i++)
            if (m_data_byteen[i] && m_data_addr < 32'(4*DM_WORDS))
                mem[m_data_addr[13:2]][8*i +: 8] = m_data_wdata[8*i +: 8];
        if (!rst_n) begin
            mdl_m.valid = 1'b0;
            mdl_w.valid = 1'b0;
            mdl_known   = 1'b1;
        end else if (mdl_known) begin
            nw = '{valid: 1'b0, load: 1'b0, fault: 1'b0, rd: 5'd0, data: 32'h0, pc: 32'h0};
            if (mdl_m.valid && !st) begin
                nw.valid = 1'b1;
                nw.load  = (mdl_m.op <= LBU);
                nw.fault = ref_fault(mdl_m.op, mdl_m.addr);
                nw.rd    = mdl_m.rd;
                nw.pc    = mdl_m.pc;
                if (nw.load && !nw.fault) nw.data = ref_load(mdl_m.op, mdl_m.addr);
                if (!nw.load && !nw.fault) begin
                    mask  = ref_mask(mdl_m.op, mdl_m.addr);
                    lanes = ref_lanes(mdl_m.op, mdl_m.wdata);
                    for (int i = 0; i < 4; i++)
                        if (mask[i]) ref_mem[mdl_m.addr[13:2]][8*i +: 8] = lanes[8*i +: 8];
                end
            end
            if (v && exp_ready) nm = '{valid: 1'b1, op: op, addr: addr, wdata: wdata, pc: pc, rd: rd};
            else if (st && mdl_m.valid) nm = mdl_m;
            else begin
                nm = mdl_m;
                nm.valid = 1'b0;
            end
            mdl_m = nm;
            mdl_w = nw;
        end
    endtask

    task automatic idle(input logic rst_n);
        do_cycle(1'b0, LW, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, rst_n);
    endtask

    vec_t vecs [18];
    int   pulses;

    initial begin
        mdl_m = '{valid: 1'b0, op: 3'd0, addr: 32'h0, wdata: 32'h0, pc: 32'h0, rd: 5'd0};
        mdl_w = '{valid: 1'b0, load: 1'b0, fault: 1'b0, rd: 5'd0, data: 32'h0, pc: 32'h0};
        for (int i = 0; i < DM_WORDS; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        //        op   addr        wdata         pc          rd    be     maddr       mwdata        we    wdata         exc
        vecs[0]  = '{SW,  32'h10,   32'h12345678, 32'h3000, 5'd0,  4'hF, 32'h10,   32'h12345678, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{LW,  32'h10,   32'h0,        32'h3004, 5'd5,  4'h0, 32'h10,   32'h0,        1'b1, 32'h12345678, 1'b0};
        vecs[2]  = '{SB,  32'h13,   32'hAB,       32'h3010, 5'd0,  4'h8, 32'h10,   32'hABABABAB, 1'b0, 32'h0,        1'b0};
        vecs[3]  = '{LB,  32'h13,   32'h0,        32'h3014, 5'd8,  4'h0, 32'h10,   32'h0,        1'b1, 32'hFFFFFFAB, 1'b0};
        vecs[4]  = '{LBU, 32'h13,   32'h0,        32'h3018, 5'd9,  4'h0, 32'h10,   32'h0,        1'b1, 32'h000000AB, 1'b0};
        vecs[5]  = '{SH,  32'h22,   32'h8001,     32'h301C, 5'd0,  4'hC, 32'h20,   32'h80018001, 1'b0, 32'h0,        1'b0};
        vecs[6]  = '{LH,  32'h22,   32'h0,        32'h3020, 5'd10, 4'h0, 32'h20,   32'h0,        1'b1, 32'hFFFF8001, 1'b0};
        vecs[7]  = '{LHU, 32'h22,   32'h0,        32'h3024, 5'd11, 4'h0, 32'h20,   32'h0,        1'b1, 32'h00008001, 1'b0};
        vecs[8]  = '{LW,  32'h6,    32'h0,        32'h3008, 5'd3,  4'h0, 32'h4,    32'h0,        1'b0, 32'h0,        1'b1};
        vecs[9]  = '{SW,  32'h4000, 32'hCAFEF00D, 32'h300C, 5'd0,  4'h0, 32'h4000, 32'hCAFEF00D, 1'b0, 32'h0,        1'b1};
        vecs[10] = '{LB,  32'h10,   32'h0,        32'h3028, 5'd0,  4'h0, 32'h10,   32'h0,        1'b0, 32'h0,        1'b0};
        vecs[11] = '{SH,  32'h21,   32'h1234,     32'h302C, 5'd0,  4'h0, 32'h20,   32'h12341234, 1'b0, 32'h0,        1'b1};
        vecs[12] = '{LH,  32'h12,   32'h0,        32'h3030, 5'd12, 4'h0, 32'h10,   32'h0,        1'b1, 32'hFFFFAB34, 1'b0};
        vecs[13] = '{SB,  32'h3FFF, 32'h5A,       32'h3034, 5'd0,  4'h8, 32'h3FFC, 32'h5A5A5A5A, 1'b0, 32'h0,        1'b0};
        vecs[14] = '{LBU, 32'h3FFF, 32'h0,        32'h3038, 5'd13, 4'h0, 32'h3FFC, 32'h0,        1'b1, 32'h0000005A, 1'b0};
        vecs[15] = '{LB,  32'h4000, 32'h0,        32'h303C, 5'd1,  4'h0, 32'h4000, 32'h0,        1'b0, 32'h0,        1'b1};
        vecs[16] = '{SB,  32'h11,   32'hFFFFFF01, 32'h3040, 5'd0,  4'h2, 32'h10,   32'h01010101, 1'b0, 32'h0,        1'b0};
        vecs[17] = '{LW,  32'h10,   32'h0,        32'h3044, 5'd31, 4'h0, 32'h10,   32'h0,        1'b1, 32'hAB340178, 1'b0};

        idle(1'b0);
        idle(1'b0);
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_byteen", 32'(m_data_byteen), 32'h0);
        check("rst_m_inst_addr", m_inst_addr, 32'h0);
        check("rst_m_data_addr", m_data_addr, 32'h0);
        check("rst_w_grf_we", 32'(w_grf_we), 32'h0);
        check("rst_exc_valid", 32'(exc_valid), 32'h0);

        // The first vector is issued on the first edge with reset high.
        foreach (vecs[k]) begin
            do_cycle(1'b1, vecs[k].op, vecs[k].addr, vecs[k].wdata, vecs[k].pc, vecs[k].rd, 1'b0, 1'b1);
            idle(1'b1);
            check("vec_byteen", 32'(m_data_byteen), 32'(vecs[k].e_be));
            check("vec_m_data_addr", m_data_addr, vecs[k].e_maddr);
            check("vec_m_data_wdata", m_data_wdata, vecs[k].e_mwdata);
            idle(1'b1);
            check("vec_w_grf_we", 32'(w_grf_we), 32'(vecs[k].e_we));
            if (vecs[k].e_we) begin
                check("vec_w_grf_addr", 32'(w_grf_addr), 32'(vecs[k].rd));
                check("vec_w_grf_wdata", w_grf_wdata, vecs[k].e_wdata);
            end
            check("vec_exc_valid", 32'(exc_valid), 32'(vecs[k].e_exc));
            check("vec_exc_pc", exc_pc, vecs[k].e_exc ? vecs[k].pc : 32'h0);
            check("vec_w_inst_addr", w_inst_addr, vecs[k].pc);
        end

        // Store held in M by stall, with a load waiting behind it.
        pulses = 0;
        do_cycle(1'b1, SW, 32'h30, 32'hDEADBEEF, 32'h4000, 5'd0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            do_cycle(1'b1, LW, 32'h30, 32'h0, 32'h4004, 5'd4, 1'b1, 1'b1);
            check("stall_req_ready", 32'(req_ready), 32'h0);
            check("stall_byteen", 32'(m_data_byteen), 32'h0);
            check("stall_w_bubble", w_inst_addr, 32'h0);
            if (m_data_byteen == 4'hF) pulses++;
        end
        do_cycle(1'b1, LW, 32'h30, 32'h0, 32'h4004, 5'd4, 1'b0, 1'b1);
        check("release_byteen", 32'(m_data_byteen), 32'hF);
        if (m_data_byteen == 4'hF) pulses++;
        idle(1'b1);
        if (m_data_byteen == 4'hF) pulses++;
        check("release_w_inst_addr", w_inst_addr, 32'h4000);
        check("release_m_inst_addr", m_inst_addr, 32'h4004);
        idle(1'b1);
        check("stall_pulses", 32'(pulses), 32'd1);
        check("b2b_w_grf_we", 32'(w_grf_we), 32'h1);
        check("b2b_w_grf_wdata", w_grf_wdata, 32'hDEADBEEF);

        // Reset lands while a byte store sits in M.
        do_cycle(1'b1, SB, 32'h40, 32'hCD, 32'h5000, 5'd0, 1'b0, 1'b1);
        idle(1'b0);
        check("rst_sb_byteen", 32'(m_data_byteen), 32'h0);
        idle(1'b1);
        check("post_rst_req_ready", 32'(req_ready), 32'h1);
        check("post_rst_outputs", {m_data_addr | m_data_wdata | m_inst_addr | w_grf_wdata |
                                   w_inst_addr | exc_pc}, 32'h0);
        check("post_rst_flags", 32'({m_data_byteen, w_grf_we, w_grf_addr, exc_valid}), 32'h0);
        do_cycle(1'b1, LBU, 32'h40, 32'h0, 32'h5004, 5'd6, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        check("rst_sb_not_written", w_grf_wdata, 32'h0);
        check("rst_sb_load_we", 32'(w_grf_we), 32'h1);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = 32'h3FF8 + $urandom_range(0, 15);
            else a = $urandom_range(0, 127);
            do_cycle($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), a, $urandom,
                     32'h6000 + 32'(4 * n), 5'($urandom_range(0, 31)),
                     $urandom_range(0, 3) == 0, $urandom_range(0, 49) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
